// File: rtl/kpg_pkg.sv
// Shared KPG carry-network types and helpers for the pipelined add/sub datapath.
// A KPG entry marks whether a span kills (K), propagates (P) or generates (G) a carry.
package kpg_pkg;

  typedef logic [1:0] kpg_t;

  localparam kpg_t KPG_K = 2'b00;
  localparam kpg_t KPG_P = 2'b01;
  localparam kpg_t KPG_G = 2'b11;

  localparam int SUB_WIDTH = 16;
  localparam int SUB_LAT   = 5;
  // Entry 0 is the carry-in position; entries 1..16 are operand bits 0..15.
  localparam int KPG_N     = SUB_WIDTH + 1;

  // hi dominates unless it merely propagates, in which case lo decides.
  function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
    return (hi == KPG_P) ? lo : hi;
  endfunction

  // {x&y, x|y} yields 00=K, 01=P, 11=G directly from the two addend bits.
  function automatic kpg_t kpg_encode(input logic x, input logic y);
    return {x & y, x | y};
  endfunction

endpackage

// File: rtl/kpg_prefix_stage.sv
// One prefix level (span SPAN) of the KPG network plus valid bit and sideband; 1 cycle.
// Holds all contents, bubbles included, while en_i is low.
module kpg_prefix_stage
  import kpg_pkg::*;
#(
  parameter int SPAN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   vld_i,
  input  logic [2*KPG_N-1:0]     kpg_i,
  input  logic [SUB_WIDTH-1:0]   hx_i,
  input  logic                   a15_i,
  input  logic                   b15_i,
  output logic                   vld_o,
  output logic [2*KPG_N-1:0]     kpg_o,
  output logic [SUB_WIDTH-1:0]   hx_o,
  output logic                   a15_o,
  output logic                   b15_o
);

  logic [2*KPG_N-1:0]   kpg_d;
  logic [2*KPG_N-1:0]   kpg_q;
  logic [SUB_WIDTH-1:0] hx_q;
  logic                 vld_q;
  logic                 a15_q;
  logic                 b15_q;

  genvar j;
  for (j = 0; j < KPG_N; j++) begin : g_ent
    if (j >= SPAN) begin : g_comb
      assign kpg_d[2*j +: 2] = kpg_combine(kpg_i[2*j +: 2], kpg_i[2*(j-SPAN) +: 2]);
    end else begin : g_pass
      assign kpg_d[2*j +: 2] = kpg_i[2*j +: 2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      kpg_q <= '0;
      hx_q  <= '0;
      a15_q <= 1'b0;
      b15_q <= 1'b0;
    end else if (en_i) begin
      vld_q <= vld_i;
      kpg_q <= kpg_d;
      hx_q  <= hx_i;
      a15_q <= a15_i;
      b15_q <= b15_i;
    end
  end

  assign vld_o = vld_q;
  assign kpg_o = kpg_q;
  assign hx_o  = hx_q;
  assign a15_o = a15_q;
  assign b15_o = b15_q;

endmodule

// File: rtl/kpg_sub16_pipe.sv
// Pipelined 16-bit subtractor a - b - borrow_in over a 4-level KPG prefix network; 5 cycles.
// Any output stall (out_valid & ~out_ready) freezes every stage and drops in_ready.
module kpg_sub16_pipe
  import kpg_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic stall;
  logic en;
  logic acc;

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;
  assign acc      = in_valid & in_ready;

  // ---------------- S0: operands and initial KPG vector ----------------
  logic [2*KPG_N-1:0]   s0_kpg_d;
  logic [2*KPG_N-1:0]   s0_kpg_q;
  logic [SUB_WIDTH-1:0] s0_a_q;
  logic [SUB_WIDTH-1:0] s0_b_q;
  logic                 s0_vld_q;

  always_comb begin
    s0_kpg_d      = '0;
    s0_kpg_d[1:0] = borrow_in ? KPG_K : KPG_G;
    for (int i = 0; i < SUB_WIDTH; i++) begin
      s0_kpg_d[2*(i+1) +: 2] = kpg_encode(a[i], ~b[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q <= 1'b0;
      s0_a_q   <= '0;
      s0_b_q   <= '0;
      s0_kpg_q <= '0;
    end else if (en) begin
      s0_vld_q <= acc;
      s0_a_q   <= a;
      s0_b_q   <= b;
      s0_kpg_q <= s0_kpg_d;
    end
  end

  // ---------------- S1..S4: prefix levels, spans 1, 2, 4, 8 ----------------
  logic [4:0]           vld_a;
  logic [2*KPG_N-1:0]   kpg_a [5];
  logic [SUB_WIDTH-1:0] hx_a  [5];
  logic [4:0]           a15_a;
  logic [4:0]           b15_a;

  assign vld_a[0] = s0_vld_q;
  assign kpg_a[0] = s0_kpg_q;
  assign hx_a[0]  = s0_a_q ^ ~s0_b_q;
  assign a15_a[0] = s0_a_q[SUB_WIDTH-1];
  assign b15_a[0] = s0_b_q[SUB_WIDTH-1];

  genvar k;
  for (k = 0; k < 4; k++) begin : g_lvl
    kpg_prefix_stage #(
      .SPAN(1 << k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .vld_i (vld_a[k]),
      .kpg_i (kpg_a[k]),
      .hx_i  (hx_a[k]),
      .a15_i (a15_a[k]),
      .b15_i (b15_a[k]),
      .vld_o (vld_a[k+1]),
      .kpg_o (kpg_a[k+1]),
      .hx_o  (hx_a[k+1]),
      .a15_o (a15_a[k+1]),
      .b15_o (b15_a[k+1])
    );
  end

  // ---------------- Output rank: sum bits and flags ----------------
  logic [SUB_WIDTH-1:0] diff_d;
  logic [SUB_WIDTH-1:0] diff_q;
  kpg_t                 cout_k;
  logic                 borrow_d;
  logic                 zero_d;
  logic                 neg_d;
  logic                 ovf_d;
  logic                 borrow_q;
  logic                 zero_q;
  logic                 neg_q;
  logic                 ovf_q;
  logic                 out_vld_q;
  logic                 s4_resolved;

  // Entry 16 only spans bits 0..15 after four levels; the carry-in is folded in here.
  always_comb begin
    diff_d = '0;
    for (int i = 0; i < SUB_WIDTH; i++) begin
      diff_d[i] = hx_a[4][i] ^ (kpg_a[4][2*i +: 2] == KPG_G);
    end
    cout_k   = kpg_combine(kpg_a[4][2*SUB_WIDTH +: 2], kpg_a[4][1:0]);
    borrow_d = (cout_k != KPG_G);
    zero_d   = (diff_d == '0);
    neg_d    = diff_d[SUB_WIDTH-1];
    ovf_d    = (a15_a[4] ^ b15_a[4]) & (a15_a[4] ^ diff_d[SUB_WIDTH-1]);
  end

  always_comb begin
    s4_resolved = (cout_k != KPG_P);
    for (int i = 0; i < SUB_WIDTH; i++) begin
      if (kpg_a[4][2*i +: 2] == KPG_P) begin
        s4_resolved = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (en) begin
      out_vld_q <= vld_a[4];
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = out_vld_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

  a_s4_resolved: assert property (@(posedge clk) disable iff (!rst_n) vld_a[4] |-> s4_resolved);

endmodule

// File: tb/tb_kpg_sub16_pipe.sv
// Scoreboard bench for kpg_sub16_pipe: driver pushes expected results, monitor pops on each transfer.
module tb_kpg_sub16_pipe;
  import kpg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        borrow_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff;
  logic        borrow, zero, neg, ovf;

  kpg_sub16_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;     // {borrow, zero, neg, ovf}
    int          acc;
    bit          lat;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   beat_id = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (beat %0d): got 0x%0h, expected 0x%0h", nm, id, act, exp);
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    exp_t e;
    logic [16:0] r;
    r     = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
    e.d   = r[15:0];
    e.f   = {r[16], (r[15:0] == 16'd0), r[15], (av[15] ^ bv[15]) & (av[15] ^ r[15])};
    e.acc = 0;
    e.lat = 1'b0;
    e.id  = 0;
    return e;
  endfunction

  task automatic offer(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                       input bit rdy, input bit lat, input exp_t ex, output bit took);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    borrow_in = bi;
    out_ready = rdy;
    #1;
    took = in_ready;
    if (took) begin
      e     = ex;
      e.acc = cyc + 1;
      e.lat = lat;
      e.id  = beat_id++;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 60) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #3;
      t++;
    end
    check("drain", -1, 32'(q.size()), 32'd0);
  endtask

  // Monitor: compares on every transfer, and watches hold behaviour during stalls.
  bit          prev_stall = 1'b0;
  logic [19:0] prev_val = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          check("stall_in_ready", -1, 32'(in_ready), 32'd0);
          if (prev_stall) check("stall_hold", -1, 32'({diff, borrow, zero, neg, ovf}), 32'(prev_val));
          prev_stall = 1'b1;
          prev_val   = {diff, borrow, zero, neg, ovf};
        end else begin
          prev_stall = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_beat: got diff 0x%0h, expected no beat", diff);
          end else begin
            e = q.pop_front();
            check("diff", e.id, 32'(diff), 32'(e.d));
            check("flags", e.id, 32'({borrow, zero, neg, ovf}), 32'(e.f));
            if (e.lat) check("latency", e.id, 32'(cyc), 32'(e.acc + SUB_LAT));
          end
        end
      end
    end
  end

  // Hand-computed directed vectors.
  logic [15:0] va [6] = '{16'h1234, 16'h0000, 16'h5A5A, 16'h8000, 16'h7FFF, 16'hBEEF};
  logic [15:0] vb [6] = '{16'h0234, 16'h0001, 16'h5A5A, 16'h0001, 16'hFFFF, 16'hBEEF};
  logic        vc [6] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
  logic [15:0] vd [6] = '{16'h1000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
  logic [3:0]  vf [6] = '{4'b0000,  4'b1010,  4'b1010,  4'b0001,  4'b1011,  4'b0100};

  initial begin
    exp_t        ex;
    bit          took;
    logic [15:0] ra, rb;
    logic        rbi;
    int          i, c;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", -1, 32'(out_valid), 32'd0);
    check("reset_outputs", -1, 32'({diff, borrow, zero, neg, ovf}), 32'd0);
    check("reset_in_ready", -1, 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle(2);

    // Basic beat alone, then the remaining directed cases back to back.
    for (int k = 0; k < 6; k++) begin
      ex   = model(va[k], vb[k], vc[k]);
      ex.d = vd[k];
      ex.f = vf[k];
      offer(va[k], vb[k], vc[k], 1'b1, 1'b1, ex, took);
      check("accept_directed", k, 32'(took), 32'd1);
      if (k == 0) idle(7);
    end
    drain();

    // Back-to-back pseudo-random stream against the reference model.
    for (int k = 0; k < 8; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom_range(0, 1));
      offer(ra, rb, rbi, 1'b1, 1'b1, model(ra, rb, rbi), took);
      check("accept_stream", k, 32'(took), 32'd1);
    end
    drain();

    // Backpressure: out_ready low for 4 cycles once results are flowing.
    i    = 0;
    c    = 0;
    took = 1'b1;
    ra   = '0;
    rb   = '0;
    rbi  = 1'b0;
    while (i < 10 && c < 40) begin
      if (took) begin
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        rbi = 1'(i % 2);
      end
      offer(ra, rb, rbi, !(c >= 7 && c < 11), 1'b0, model(ra, rb, rbi), took);
      if (took) i++;
      c++;
    end
    check("bp_all_accepted", -1, 32'(i), 32'd10);
    drain();

    // Reset with three beats in flight, released between edges.
    offer(16'h1111, 16'h0001, 1'b0, 1'b1, 1'b1, model(16'h1111, 16'h0001, 1'b0), took);
    offer(16'h2222, 16'h0002, 1'b0, 1'b1, 1'b1, model(16'h2222, 16'h0002, 1'b0), took);
    offer(16'h3333, 16'h0003, 1'b1, 1'b1, 1'b1, model(16'h3333, 16'h0003, 1'b1), took);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    q.delete();
    #1;
    check("midreset_out_valid", -1, 32'(out_valid), 32'd0);
    check("midreset_outputs", -1, 32'({diff, borrow, zero, neg, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    check("midreset_hold", -1, 32'(out_valid), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_in_ready", -1, 32'(in_ready), 32'd1);
    ex   = model(16'h0003, 16'h0001, 1'b0);
    ex.d = 16'h0002;
    ex.f = 4'b0000;
    offer(16'h0003, 16'h0001, 1'b0, 1'b1, 1'b1, ex, took);
    check("accept_post_reset", -1, 32'(took), 32'd1);
    drain();
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
